// File: rtl/bcd_cnt60.sv
// -----------------------------------------------------------------------------
// bcd_cnt60
// Two-digit BCD modulo-((TENS_MAX+1)*10) counter. This is the seconds/minutes
// stage of the asynchronous counter chain. It counts up or down, supports a
// synchronous load, and produces a one-cycle terminal-count pulse and a
// divided clock for the next stage.
//
// Parameters:
//   TENS_MAX  highest tens digit (odd, <= 9); modulus = (TENS_MAX+1)*10
//
// Ports:
//   clk      in   counting clock (upstream clk0 in the chain)
//   rst      in   asynchronous reset, active-low
//   en       in   count enable
//   dir      in   1 = count up, 0 = count down
//   load     in   synchronous load request (has priority over en)
//   ld_ones  in   BCD ones digit to load
//   ld_tens  in   BCD tens digit to load
//   ones     out  ones digit, 0..9
//   tens     out  tens digit, 0..TENS_MAX
//   tc       out  terminal-count pulse, high in the cycle showing the wrapped value
//   err      out  invalid-load pulse; the count is held
//   clk1     out  divided clock, period = modulus cycles, 50% duty
// -----------------------------------------------------------------------------
module bcd_cnt60 #(
  parameter int TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] ld_ones,
  input  logic [3:0] ld_tens,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       tc,
  output logic       err,
  output logic       clk1
);

  localparam logic [3:0] TENS_TOP  = 4'(TENS_MAX);
  localparam logic [3:0] TENS_HALF = 4'((TENS_MAX + 1) / 2);
  localparam logic [3:0] ONES_TOP  = 4'd9;

  logic [3:0] ones_reg, ones_next;
  logic [3:0] tens_reg, tens_next;
  logic       tc_reg, tc_next;
  logic       err_reg, err_next;
  logic       clk1_reg, clk1_next;
  logic       step;
  logic       ld_valid;

  assign ld_valid = (ld_ones <= ONES_TOP) && (ld_tens <= TENS_TOP);

  always_comb begin
    ones_next = ones_reg;
    tens_next = tens_reg;
    tc_next   = 1'b0;
    err_next  = 1'b0;
    clk1_next = clk1_reg;
    step      = 1'b0;

    if (load) begin
      if (ld_valid) begin
        ones_next = ld_ones;
        tens_next = ld_tens;
      end else begin
        err_next = 1'b1;
      end
    end else if (en) begin
      step = 1'b1;
      if (dir) begin
        if (ones_reg == ONES_TOP) begin
          ones_next = 4'd0;
          if (tens_reg == TENS_TOP) begin
            tens_next = 4'd0;
            tc_next   = 1'b1;
          end else begin
            tens_next = tens_reg + 4'd1;
          end
        end else begin
          ones_next = ones_reg + 4'd1;
        end
      end else begin
        if (ones_reg == 4'd0) begin
          ones_next = ONES_TOP;
          if (tens_reg == 4'd0) begin
            tens_next = TENS_TOP;
            tc_next   = 1'b1;
          end else begin
            tens_next = tens_reg - 4'd1;
          end
        end else begin
          ones_next = ones_reg - 4'd1;
        end
      end
    end

    // The divided clock is set on entry to 0:0 and cleared on entry to the
    // half-way value. Under continuous counting in either direction these two
    // points alternate, so clk1 toggles there; using explicit set/clear keeps
    // the phase correct after reset (clk1 = 0 at 00, first rise at the wrap)
    // and after a load has skipped one of the two points.
    if (step && (ones_next == 4'd0)) begin
      if (tens_next == 4'd0) begin
        clk1_next = 1'b1;
      end else if (tens_next == TENS_HALF) begin
        clk1_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones_reg <= 4'd0;
      tens_reg <= 4'd0;
      tc_reg   <= 1'b0;
      err_reg  <= 1'b0;
      clk1_reg <= 1'b0;
    end else begin
      ones_reg <= ones_next;
      tens_reg <= tens_next;
      tc_reg   <= tc_next;
      err_reg  <= err_next;
      clk1_reg <= clk1_next;
    end
  end

  assign ones = ones_reg;
  assign tens = tens_reg;
  assign tc   = tc_reg;
  assign err  = err_reg;
  assign clk1 = clk1_reg;

endmodule

// File: tb/tb_bcd_cnt60.sv
// -----------------------------------------------------------------------------
// tb_bcd_cnt60
// Directed testbench for bcd_cnt60 (default TENS_MAX = 5). Each task drives
// one scenario and compares the packed observation {tens, ones, tc, err, clk1}
// against hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_bcd_cnt60;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       dir;
  logic       load;
  logic [3:0] ld_ones;
  logic [3:0] ld_tens;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       tc;
  logic       err;
  logic       clk1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [10:0] obs;
  logic [10:0] exp_v;
  assign obs = {tens, ones, tc, err, clk1};

  bcd_cnt60 #(.TENS_MAX(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .dir     (dir),
    .load    (load),
    .ld_ones (ld_ones),
    .ld_tens (ld_tens),
    .ones    (ones),
    .tens    (tens),
    .tc      (tc),
    .err     (err),
    .clk1    (clk1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; dir = 1'b1; load = 1'b0; ld_ones = 4'd0; ld_tens = 4'd0;
    #1;
    exp_v = {4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL reset_state: got %h want %h", obs, exp_v);
    end
    @(negedge clk);
    rst = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_up_wrap();
    int e;
    logic c;
    en = 1'b1; dir = 1'b1;
    for (int i = 1; i <= 90; i++) begin
      tick();
      e = i % 60;
      c = (i >= 60 && i < 90) ? 1'b1 : 1'b0;
      exp_v = {4'(e / 10), 4'(e % 10), (e == 0), 1'b0, c};
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL up_count step %0d: got %h want %h", i, obs, exp_v);
      end
    end
    $display("test_up_wrap done");
  endtask

  task automatic test_load_dir();
    // count is 30, clk1 = 0
    en = 1'b0; load = 1'b1; ld_tens = 4'd5; ld_ones = 4'd8;
    tick();
    exp_v = {4'd5, 4'd8, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL load_58: got %h want %h", obs, exp_v); end
    load = 1'b0; en = 1'b1; dir = 1'b1;
    tick();
    exp_v = {4'd5, 4'd9, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL up_to_59: got %h want %h", obs, exp_v); end
    tick();
    exp_v = {4'd0, 4'd0, 1'b1, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL up_wrap_00: got %h want %h", obs, exp_v); end
    dir = 1'b0;
    tick();
    exp_v = {4'd5, 4'd9, 1'b1, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL down_wrap_59: got %h want %h", obs, exp_v); end
    tick();
    exp_v = {4'd5, 4'd8, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL down_58: got %h want %h", obs, exp_v); end
    $display("test_load_dir done");
  endtask

  task automatic test_invalid_load();
    en = 1'b0; load = 1'b1; ld_tens = 4'd3; ld_ones = 4'd10;
    tick();
    exp_v = {4'd5, 4'd8, 1'b0, 1'b1, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL bad_ones_load: got %h want %h", obs, exp_v); end
    load = 1'b0;
    tick();
    exp_v = {4'd5, 4'd8, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL err_clears_1: got %h want %h", obs, exp_v); end
    load = 1'b1; ld_tens = 4'd6; ld_ones = 4'd0;
    tick();
    exp_v = {4'd5, 4'd8, 1'b0, 1'b1, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL bad_tens_load: got %h want %h", obs, exp_v); end
    load = 1'b0;
    tick();
    exp_v = {4'd5, 4'd8, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL err_clears_2: got %h want %h", obs, exp_v); end
    $display("test_invalid_load done");
  endtask

  task automatic test_load_en();
    load = 1'b1; en = 1'b0; ld_tens = 4'd5; ld_ones = 4'd9;
    tick();
    exp_v = {4'd5, 4'd9, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL load_59: got %h want %h", obs, exp_v); end
    en = 1'b1; dir = 1'b1; ld_tens = 4'd2; ld_ones = 4'd5;
    tick();
    exp_v = {4'd2, 4'd5, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL load_beats_en: got %h want %h", obs, exp_v); end
    $display("test_load_en done");
  endtask

  task automatic test_hold();
    load = 1'b1; en = 1'b0; ld_tens = 4'd2; ld_ones = 4'd9;
    tick();
    load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_v = {4'd2, 4'd9, 1'b0, 1'b0, 1'b1};
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL hold cycle %0d: got %h want %h", i, obs, exp_v); end
    end
    $display("test_hold done");
  endtask

  task automatic test_down_borrow();
    load = 1'b1; en = 1'b0; ld_tens = 4'd4; ld_ones = 4'd0;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b0;
    tick();
    exp_v = {4'd3, 4'd9, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL down_borrow_39: got %h want %h", obs, exp_v); end
    tick();
    exp_v = {4'd3, 4'd8, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL down_38: got %h want %h", obs, exp_v); end
    $display("test_down_borrow done");
  endtask

  task automatic test_async_reset();
    load = 1'b1; en = 1'b0; ld_tens = 4'd4; ld_ones = 4'd7;
    tick();
    exp_v = {4'd4, 4'd7, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL load_47: got %h want %h", obs, exp_v); end
    load = 1'b0; en = 1'b1; dir = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    exp_v = {4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL async_clear: got %h want %h", obs, exp_v); end
    tick();
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL reset_held: got %h want %h", obs, exp_v); end
    rst = 1'b1;
    tick();
    exp_v = {4'd0, 4'd1, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL resume_01: got %h want %h", obs, exp_v); end
    tick();
    exp_v = {4'd0, 4'd2, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL resume_02: got %h want %h", obs, exp_v); end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_load_dir();
    test_invalid_load();
    test_load_en();
    test_hold();
    test_down_borrow();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_cnt60.md
# bcd_cnt60

Two-digit BCD modulo-60 counter that consumes the divided clock produced by the upstream decade divider. It advances once per rising edge while enabled, and supports synchronous load, up/down direction and a terminal-count pulse. Its own divided clock output (`clk1`) feeds the next stage of the asynchronous cascade, for example an hours counter. This is the seconds/minutes stage of the async counter chain.

## Interface
Parameters:
- `TENS_MAX`, default 5: highest tens digit; modulus = (TENS_MAX+1)*10. Must be odd so the half-period point is integral.

Ports:
- `clk` in 1: counting clock; in the chain this is the upstream `clk0`.
- `rst` in 1: reset, asynchronous, active-low.
- `en` in 1: count enable, sampled at posedge `clk`.
- `dir` in 1: 1 = count up, 0 = count down.
- `load` in 1: synchronous load request.
- `ld_ones` in 4: BCD ones value to load.
- `ld_tens` in 4: BCD tens value to load.
- `ones` out 4: ones digit, 0..9.
- `tens` out 4: tens digit, 0..TENS_MAX.
- `tc` out 1: terminal-count pulse, one cycle wide.
- `err` out 1: invalid-load pulse, one cycle wide.
- `clk1` out 1: divided clock for the next stage; period = modulus cycles, 50% duty.

## Operation
- All outputs are registered.
- While `rst` = 0: `ones`, `tens`, `tc`, `err` and `clk1` are forced to 0 immediately, independent of `clk`.
- Priority at each posedge: `load` > `en` > hold.
- Load with `ld_ones` ≤ 9 and `ld_tens` ≤ TENS_MAX:
  - Count takes the load value.
  - `tc` = 0, `err` = 0.
  - `clk1` unchanged.
- Load with an invalid value:
  - Count holds.
  - `err` = 1 for one cycle.
  - `tc` = 0; `clk1` unchanged.
- Count up (`en` = 1, `dir` = 1):
  - ones 9 → 0 with tens incremented.
  - At TENS_MAX:9 the count wraps to 0:0 and `tc` = 1.
- Count down (`en` = 1, `dir` = 0):
  - ones 0 → 9 with tens decremented.
  - At 0:0 the count wraps to TENS_MAX:9 and `tc` = 1.
- `clk1` toggles only on a counting step (never on load or hold), and only when the new count equals 0:0 or ((TENS_MAX+1)/2):0.
  - Up counting gives one full `clk1` period per wrap: rising edge on entry to 0:0, falling edge on entry to 30.
  - Down counting toggles on entry to 30 and to 00.
- `tc` and `err` are 0 in every cycle not listed above.
- `dir` may change on any cycle; it takes effect on the next counting edge.
- Digits never leave the legal BCD range (no illegal states after reset).

## Timing
- Latency: a count, load, `tc`, `err` or `clk1` change appears on the same posedge at which `en`/`load` is sampled high. No combinational path from inputs to outputs.
- `tc` is high exactly in the cycle where the count shows the wrapped value: 00 when counting up, 59 when counting down with default parameters.
- Continuous up count: `tc` period = 60 cycles; `clk1` is high for 30 cycles and low for 30 cycles.
- `load` and `en` both high on the same edge: the load wins, no count step occurs, and no `tc` is produced.
- Reset asserted mid-count: outputs clear asynchronously. Counting resumes from 00 at the first posedge after `rst` deasserts with `en` = 1, giving 01.

## Test plan
- Reset then `en` = 1, `dir` = 1 for 60 edges:
  - Sequence 00, 01 … 09, 10 … 59, 00.
  - `tc` = 1 only at the cycle showing 00.
  - `clk1` rises at 00 and falls at 30.
- Load 58 with `dir` = 1 → 59, then 00 with `tc` = 1. Switch to `dir` = 0 → 59 with `tc` = 1, then 58.
- Load invalid values: `ld_ones` = 10 / `ld_tens` = 3 → `err` = 1 for one cycle with the count held. Then load `ld_tens` = 6 / `ld_ones` = 0 → `err` = 1 again with the count held.
- `load` and `en` together with value 25 at count 59 → count becomes 25, `tc` = 0, `clk1` unchanged.
- `en` = 0 for 20 cycles at count 29 → count, `tc` and `clk1` all stable.
- Assert `rst` asynchronously mid-cycle at count 47 → all outputs 0 before the next edge. After release, the next enabled edge gives 01.
